// File: rtl/cache_pkg.sv
// Shared cache constants and types for the PLRU state store.
package cache_pkg;
    localparam int WAYS     = 4;
    localparam int LOG_WAYS = 2;
    localparam int LOG_SETS = 6;
    localparam int SETS     = 1 << LOG_SETS;

    typedef logic [WAYS-2:0]     plru_tree_t;
    typedef logic [LOG_WAYS-1:0] way_t;
    typedef logic [LOG_SETS-1:0] set_idx_t;

    typedef enum logic {ST_INIT, ST_RUN} lru_state_e;
endpackage

// File: rtl/lru_state_array_if.sv
// Lookup-result request and way-selection response bundle for lru_state_array.
interface lru_state_array_if;
    logic               req_valid;
    logic               req_ready;
    cache_pkg::set_idx_t req_index;
    logic               req_hit;
    cache_pkg::way_t    req_way;
    logic               resp_valid;
    cache_pkg::way_t    resp_way;
    cache_pkg::set_idx_t resp_index;

    modport master (
        output req_valid, req_index, req_hit, req_way,
        input  req_ready, resp_valid, resp_way, resp_index
    );

    modport slave (
        input  req_valid, req_index, req_hit, req_way,
        output req_ready, resp_valid, resp_way, resp_index
    );
endinterface

// File: rtl/plru_next.sv
// Combinational tree-PLRU step: picks the victim from a heap-ordered tree and
// returns the tree with the touched way's path pointing away from it.
module plru_next #(
    parameter int WAYS     = cache_pkg::WAYS,
    parameter int LOG_WAYS = cache_pkg::LOG_WAYS
) (
    input  logic [WAYS-2:0]     tree_i,
    input  logic                hit_i,
    input  logic [LOG_WAYS-1:0] hit_way_i,
    output logic [LOG_WAYS-1:0] victim_o,
    output logic [LOG_WAYS-1:0] touched_o,
    output logic [WAYS-2:0]     tree_o
);
    logic [LOG_WAYS-1:0] v_node;
    logic                v_dir;
    logic [LOG_WAYS-1:0] u_node;
    logic [LOG_WAYS-1:0] u_way;
    logic                u_dir;

    // Walk root to leaf; each node bit names the LRU child and becomes the next way bit.
    always_comb begin
        v_node   = '0;
        v_dir    = 1'b0;
        victim_o = '0;
        for (int l = 0; l < LOG_WAYS; l++) begin
            v_dir    = tree_i[v_node];
            victim_o = LOG_WAYS'({victim_o, v_dir});
            v_node   = LOG_WAYS'({v_node, 1'b0}) + (v_dir ? LOG_WAYS'(2) : LOG_WAYS'(1));
        end
    end

    assign touched_o = hit_i ? hit_way_i : victim_o;

    always_comb begin
        tree_o = tree_i;
        u_node = '0;
        u_dir  = 1'b0;
        u_way  = touched_o;
        for (int l = 0; l < LOG_WAYS; l++) begin
            u_dir          = u_way[LOG_WAYS-1];
            tree_o[u_node] = ~u_dir;
            u_node         = LOG_WAYS'({u_node, 1'b0}) + (u_dir ? LOG_WAYS'(2) : LOG_WAYS'(1));
            u_way          = u_way << 1;
        end
    end
endmodule

// File: rtl/lru_state_array.sv
// Per-set PLRU tree store: two-stage pipeline, one lookup per cycle, response two edges after accept.
// Ready is low only during the post-reset clearing sweep; responses cannot be stalled.
module lru_state_array
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    lru_state_array_if.slave bus
);
    lru_state_e state_q, state_d;
    set_idx_t   cnt_q, cnt_d;

    plru_tree_t mem [SETS];
    plru_tree_t mem_rd_q;
    logic       col_q;
    plru_tree_t col_dat_q;

    logic       s1_vld_q, s2_vld_q;
    set_idx_t   s1_idx_q, s2_idx_q;
    logic       s1_hit_q, s2_hit_q;
    way_t       s1_way_q, s2_way_q;
    plru_tree_t s1_tree, s2_tree_q;

    logic       resp_valid_q;
    way_t       resp_way_q;
    set_idx_t   resp_index_q;

    way_t       victim, touched;
    plru_tree_t nxt_tree;
    logic       accept;
    logic       wr_en;
    set_idx_t   wr_idx;
    plru_tree_t wr_dat;

    assign bus.req_ready  = (state_q == ST_RUN);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_way   = resp_way_q;
    assign bus.resp_index = resp_index_q;
    assign accept         = bus.req_valid && (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + set_idx_t'(1);
                if (cnt_q == set_idx_t'(SETS - 1)) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wr_en  = (state_q == ST_INIT) || (s2_vld_q && !reset);
        wr_idx = (state_q == ST_INIT) ? cnt_q : s2_idx_q;
        wr_dat = (state_q == ST_INIT) ? '0 : nxt_tree;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_dat;
        mem_rd_q <= mem[bus.req_index];
    end

    // The RAM returns old data when read and written on the same edge, so that
    // write is captured beside the read; the S2 result is newer still and wins.
    always_comb begin
        if (s2_vld_q && (s2_idx_q == s1_idx_q)) s1_tree = nxt_tree;
        else if (col_q)                         s1_tree = col_dat_q;
        else                                    s1_tree = mem_rd_q;
    end

    plru_next #(.WAYS(WAYS), .LOG_WAYS(LOG_WAYS)) u_plru_next (
        .tree_i    (s2_tree_q),
        .hit_i     (s2_hit_q),
        .hit_way_i (s2_way_q),
        .victim_o  (victim),
        .touched_o (touched),
        .tree_o    (nxt_tree)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_index_q <= '0;
        end else begin
            s1_vld_q     <= accept;
            s2_vld_q     <= s1_vld_q;
            resp_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                resp_way_q   <= touched;
                resp_index_q <= s2_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        col_q     <= wr_en && (wr_idx == bus.req_index);
        col_dat_q <= wr_dat;
        if (accept) begin
            s1_idx_q <= bus.req_index;
            s1_hit_q <= bus.req_hit;
            s1_way_q <= bus.req_way;
        end
        if (s1_vld_q) begin
            s2_idx_q  <= s1_idx_q;
            s2_hit_q  <= s1_hit_q;
            s2_way_q  <= s1_way_q;
            s2_tree_q <= s1_tree;
        end
    end

    logic unused_victim;
    assign unused_victim = ^victim;
endmodule
